// File: rtl/mmul_pkg.sv
// Shared types and constants for the mmul host and its matrix-multiply core.
// Elements are Q16.16 words; LAT is the core's pipeline depth (multiply + sum).
package mmul_pkg;
  typedef logic [31:0] fixed_t;

  localparam int FRAC_BITS = 16;
  localparam int LAT       = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_DRAIN
  } mmul_host_state_e;
endpackage

// File: rtl/mmul_stream_host_if.sv
// Operand/result bus between the stream host and the matrix-multiply core.
// The host drives A and B and samples R.
interface mmul_if
  import mmul_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 8,
  parameter int P = 9
);
  fixed_t [M-1:0][N-1:0] A;
  fixed_t [N-1:0][P-1:0] B;
  fixed_t [M-1:0][P-1:0] R;

  modport master (output A, output B, input R);
  modport slave  (input A, input B, output R);
endinterface

// File: rtl/mmul_stream_host_rowcol_counter.sv
// Row-major 2-D index counter: column fastest, wraps to (0,0) after the last cell.
module mmul_rowcol_counter #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_adv,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_last
);
  localparam logic [RW-1:0] RMAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] CMAX = CW'(COLS - 1);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          w_col_end;

  assign w_col_end = (r_col == CMAX);
  assign o_last    = w_col_end && (r_row == RMAX);
  assign o_row     = r_row;
  assign o_col     = r_col;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      if (o_last) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_col_end) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mmul_stream_host.sv
// Streams A then B into the multiplier's operand registers, waits out the core
// latency, then streams R back out row-major with out_last on the final element.
module mmul_stream_host
  import mmul_pkg::*;
#(
  parameter int M   = 8,
  parameter int N   = 8,
  parameter int P   = 9,
  parameter int LAT = mmul_pkg::LAT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  fixed_t in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output fixed_t out_data,
  output logic   out_last,
  output logic   busy,
  mmul_if.master mmul
);
  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int WW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  mmul_host_state_e r_state, w_state_n;
  logic [WW-1:0]    r_wait;

  logic          w_load, w_in_fire, w_out_fire;
  logic          w_a_adv, w_b_adv;
  logic [MW-1:0] w_a_row, w_r_row;
  logic [NW-1:0] w_a_col, w_b_row;
  logic [PW-1:0] w_b_col, w_r_col;
  logic          w_a_last, w_b_last, w_r_last;

  // Outputs are gated by rst so the reset values show while rst is held.
  assign w_load     = (r_state == S_IDLE) || (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  assign in_ready   = w_load && !rst;
  assign out_valid  = (r_state == S_DRAIN) && !rst;
  assign busy       = (r_state != S_IDLE) && !rst;
  assign out_last   = out_valid && w_r_last;
  assign out_data   = mmul.R[w_r_row][w_r_col];
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_a_adv    = w_in_fire && ((r_state == S_IDLE) || (r_state == S_LOAD_A));
  assign w_b_adv    = w_in_fire && (r_state == S_LOAD_B);

  mmul_rowcol_counter #(.ROWS(M), .COLS(N)) u_cnt_a (
    .clk(clk), .rst(rst), .i_adv(w_a_adv),
    .o_row(w_a_row), .o_col(w_a_col), .o_last(w_a_last)
  );

  mmul_rowcol_counter #(.ROWS(N), .COLS(P)) u_cnt_b (
    .clk(clk), .rst(rst), .i_adv(w_b_adv),
    .o_row(w_b_row), .o_col(w_b_col), .o_last(w_b_last)
  );

  mmul_rowcol_counter #(.ROWS(M), .COLS(P)) u_cnt_r (
    .clk(clk), .rst(rst), .i_adv(w_out_fire),
    .o_row(w_r_row), .o_col(w_r_col), .o_last(w_r_last)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE:   if (w_in_fire) w_state_n = w_a_last ? S_LOAD_B : S_LOAD_A;
      S_LOAD_A: if (w_in_fire && w_a_last) w_state_n = S_LOAD_B;
      S_LOAD_B: if (w_in_fire && w_b_last) w_state_n = S_WAIT;
      S_WAIT:   if (r_wait == '0) w_state_n = S_DRAIN;
      S_DRAIN:  if (w_out_fire && w_r_last) w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  // WAIT spans LAT+1 cycles, so R has settled before DRAIN presents it.
  always_ff @(posedge clk) begin
    if (rst)                               r_wait <= '0;
    else if (w_b_adv && w_b_last)          r_wait <= WW'(LAT);
    else if (r_state == S_WAIT && r_wait != '0) r_wait <= r_wait - 1'b1;
  end

  // Operands are only overwritten while loading, so R stays constant through DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      mmul.A <= '0;
      mmul.B <= '0;
    end else begin
      if (w_a_adv) mmul.A[w_a_row][w_a_col] <= in_data;
      if (w_b_adv) mmul.B[w_b_row][w_b_col] <= in_data;
    end
  end
endmodule

// File: tb/tb_mmul_stream_host.sv
// Directed bench: an 8x8x9 host and a 2x2x3 host, each with a two-stage core stand-in.
module tb_mmul_stream_host;
  import mmul_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic   bin_valid, bin_ready, bout_valid, bout_ready, bout_last, bbusy;
  fixed_t bin_data, bout_data;
  logic   sin_valid, sin_ready, sout_valid, sout_ready, sout_last, sbusy;
  fixed_t sin_data, sout_data;

  mmul_if #(.M(8), .N(8), .P(9)) bmm ();
  mmul_if #(.M(2), .N(2), .P(3)) smm ();

  mmul_stream_host #(.M(8), .N(8), .P(9)) u_big (
    .clk(clk), .rst(rst),
    .in_valid(bin_valid), .in_ready(bin_ready), .in_data(bin_data),
    .out_valid(bout_valid), .out_ready(bout_ready), .out_data(bout_data),
    .out_last(bout_last), .busy(bbusy), .mmul(bmm)
  );

  mmul_stream_host #(.M(2), .N(2), .P(3)) u_sm (
    .clk(clk), .rst(rst),
    .in_valid(sin_valid), .in_ready(sin_ready), .in_data(sin_data),
    .out_valid(sout_valid), .out_ready(sout_ready), .out_data(sout_data),
    .out_last(sout_last), .busy(sbusy), .mmul(smm)
  );

  // Core stand-ins: operand register stage, then Q16.16 dot-product stage.
  fixed_t [7:0][7:0] ba1;
  fixed_t [7:0][8:0] bb1, bsum;
  fixed_t [1:0][1:0] sa1;
  fixed_t [1:0][2:0] sb1, ssum;

  always_comb begin
    bsum = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 9; c++)
        for (int k = 0; k < 8; k++)
          bsum[r][c] = bsum[r][c] + fixed_t'((longint'($signed(ba1[r][k])) *
                                              longint'($signed(bb1[k][c]))) >>> FRAC_BITS);
  end

  always_comb begin
    ssum = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        for (int k = 0; k < 2; k++)
          ssum[r][c] = ssum[r][c] + fixed_t'((longint'($signed(sa1[r][k])) *
                                              longint'($signed(sb1[k][c]))) >>> FRAC_BITS);
  end

  always_ff @(posedge clk) begin
    ba1 <= bmm.A; bb1 <= bmm.B; bmm.R <= bsum;
    sa1 <= smm.A; sb1 <= smm.B; smm.R <= ssum;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit sm, input fixed_t d, input bit gaps, output int w);
    bit ok;
    w = 0;
    if (gaps && $urandom_range(1) == 1) begin
      if (sm) sin_valid = 1'b0; else bin_valid = 1'b0;
      @(posedge clk); #1;
    end
    if (sm) begin sin_valid = 1'b1; sin_data = d; end
    else    begin bin_valid = 1'b1; bin_data = d; end
    do begin
      @(negedge clk);
      ok = sm ? sin_ready : bin_ready;
      @(posedge clk);
      if (!ok) w++;
    end while (!ok && w < 200);
    #1;
    if (sm) sin_valid = 1'b0; else bin_valid = 1'b0;
    chk("push_accepted", 32'(ok), 1);
  endtask

  // kind 0: A = identity, B = (i+1).0 row-major; kind 1: A all 2.0, B all 0.5
  task automatic load(input bit sm, input int kind, input bit gaps, output int first_w);
    int m = sm ? 2 : 8;
    int n = sm ? 2 : 8;
    int p = sm ? 3 : 9;
    int w;
    first_w = 0;
    for (int i = 0; i < m * n; i++) begin
      push(sm, (kind == 0) ? ((i / n == i % n) ? 32'h0001_0000 : 32'h0) : 32'h0002_0000, gaps, w);
      if (i == 0) first_w = w;
    end
    for (int i = 0; i < n * p; i++)
      push(sm, (kind == 0) ? 32'((i + 1) << 16) : 32'h0000_8000, gaps, w);
  endtask

  // mode 0: out_ready always high; mode 1: out_ready pattern 1,0,0,1
  task automatic collect(input bit sm, input int kind, input int mode, input int stop_at,
                         output int lat);
    int nb = sm ? 6 : 72;
    int beat = 0;
    int k = 0;
    int g = 0;
    bit rdy;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      chk("wait_in_ready", 32'(sm ? sin_ready : bin_ready), 0);
    end while (!(sm ? sout_valid : bout_valid) && lat < 20);
    while (beat < nb && beat < stop_at && g < 1000) begin
      rdy = (mode == 0) || (k % 4 == 0) || (k % 4 == 3);
      k++; g++;
      if (sm) sout_ready = rdy; else bout_ready = rdy;
      @(negedge clk);
      chk("out_valid", 32'(sm ? sout_valid : bout_valid), 1);
      chk("out_data", sm ? sout_data : bout_data,
          (kind == 0) ? 32'((beat + 1) << 16) : 32'h0008_0000);
      chk("out_last", 32'(sm ? sout_last : bout_last), 32'(beat == nb - 1));
      chk("drain_in_ready", 32'(sm ? sin_ready : bin_ready), 0);
      @(posedge clk); #1;
      if (rdy) beat++;
    end
    if (sm) sout_ready = 1'b0; else bout_ready = 1'b0;
    chk("drain_beats", 32'(beat), 32'((stop_at < nb) ? stop_at : nb));
    if (beat == nb) begin
      chk("end_out_valid", 32'(sm ? sout_valid : bout_valid), 0);
      chk("end_busy", 32'(sm ? sbusy : bbusy), 0);
      chk("end_in_ready", 32'(sm ? sin_ready : bin_ready), 1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, lat;
    rst = 1'b1;
    bin_valid = 1'b0; bin_data = '0; bout_ready = 1'b0;
    sin_valid = 1'b0; sin_data = '0; sout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bin_ready), 0);
    chk("rst_out_valid", 32'(bout_valid), 0);
    chk("rst_out_last", 32'(bout_last), 0);
    chk("rst_busy", 32'(bbusy), 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(bin_ready), 1);
    chk("idle_busy_sm", 32'(sbusy), 0);

    // Identity x B on the 2x2x3 host
    load(1, 0, 0, w);
    collect(1, 0, 0, 99, lat);
    chk("sm_latency", 32'(lat), 3);

    // Gap-free run on 8x8x9: first out_valid LAT+1 cycles after last B beat
    load(0, 0, 0, w);
    collect(0, 0, 0, 99, lat);
    chk("latency", 32'(lat), 3);

    // Backpressure 1,0,0,1 with 2.0 x 0.5 operands, then a back-to-back set
    load(0, 1, 0, w);
    collect(0, 1, 1, 99, lat);
    load(0, 0, 0, w);
    chk("b2b_first_accept_wait", 32'(w), 0);
    collect(0, 0, 0, 99, lat);

    // Random input gaps: same results as the gap-free run
    load(0, 0, 1, w);
    collect(0, 0, 0, 99, lat);

    // Reset after 5 A beats
    for (int i = 0; i < 5; i++) push(0, 32'h0007_0000, 0, w);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstA_in_ready_held", 32'(bin_ready), 0);
    rst = 1'b0;
    #1;
    chk("rstA_in_ready", 32'(bin_ready), 1);
    chk("rstA_busy", 32'(bbusy), 0);
    chk("rstA_out_valid", 32'(bout_valid), 0);

    // Reset at the 3rd DRAIN beat
    load(0, 1, 0, w);
    collect(0, 1, 0, 2, lat);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstD_out_valid", 32'(bout_valid), 0);
    chk("rstD_out_last", 32'(bout_last), 0);
    chk("rstD_in_ready", 32'(bin_ready), 1);
    chk("rstD_busy", 32'(bbusy), 0);

    // Fresh full operation after the resets
    load(0, 0, 0, w);
    collect(0, 0, 0, 99, lat);
    chk("post_rst_latency", 32'(lat), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
